// File: rtl/conv_tx_pkg.sv
// Shared constants for the framed convolutional encoder and its decoder bench.
// Holds the default code (K=3, octal 7/5), FSM state codes and the parity helper.
package conv_tx_pkg;

   localparam int         K_DEF         = 3;
   localparam logic [2:0] G0_DEF        = 3'b111;
   localparam logic [2:0] G1_DEF        = 3'b101;
   localparam int         FRAME_LEN_DEF = 256;
   localparam int         MAX_K         = 9;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_TAIL = 2'd2;

   function automatic logic parity(input logic [MAX_K-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Rate-1/2 encoder datapath: shift register plus combinational generator parities.
// sym_o reflects bit_i in the same cycle; no backpressure, shifts only on shift_en.
module conv_enc_core
   import conv_tx_pkg::*;
#(
   parameter int             K  = K_DEF,
   parameter logic [K-1:0]   G0 = G0_DEF,
   parameter logic [K-1:0]   G1 = G1_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       shift_en,
   input  logic       bit_i,
   output logic [1:0] sym_o
);

   logic [K-2:0] sr;
   logic [K-1:0] w;

   // sr[K-2] is the most recent previous bit, so the window is {bit, sr}.
   assign w     = {bit_i, sr};
   assign sym_o = {parity(MAX_K'(w & G0)), parity(MAX_K'(w & G1))};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr <= '0;
      end else if (clr) begin
         sr <= '0;
      end else if (shift_en) begin
         sr <= w[K-1:1];
      end
   end

endmodule

// File: rtl/conv_tx_framer.sv
// Framed convolutional encoder: FRAME_LEN info bits then K-1 zero tail bits per frame.
// Outputs registered (1 cycle); input stalls during tail, no output backpressure.
module conv_tx_framer
   import conv_tx_pkg::*;
#(
   parameter int           K         = K_DEF,
   parameter logic [K-1:0] G0        = G0_DEF,
   parameter logic [K-1:0] G1        = G1_DEF,
   parameter int           FRAME_LEN = FRAME_LEN_DEF,
   parameter int           CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             d_in,
   input  logic             abort_i,
   output logic             valid_o,
   output logic [1:0]       d_out,
   output logic             sof_o,
   output logic             eof_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] frame_cnt_o
);

   localparam int BC_W = $clog2(FRAME_LEN + 1);
   localparam int TC_W = (K > 2) ? $clog2(K - 1) : 1;
   localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(FRAME_LEN - 1);
   localparam logic [TC_W-1:0] LAST_TAIL = TC_W'(K - 2);

   logic [1:0]      state;
   logic [BC_W-1:0] bit_cnt;
   logic [TC_W-1:0] tail_cnt;
   logic [1:0]      sym;
   logic            accept;
   logic            tail_step;
   logic            tail_last;
   logic            shift_en;
   logic            enc_bit;

   assign in_ready_o = (state != ST_TAIL);
   assign busy_o     = (state != ST_IDLE);
   assign accept     = in_valid_i && in_ready_o && !abort_i;
   assign tail_step  = (state == ST_TAIL) && !abort_i;
   assign tail_last  = tail_step && (tail_cnt == LAST_TAIL);
   assign shift_en   = accept || tail_step;
   assign enc_bit    = (state == ST_TAIL) ? 1'b0 : d_in;

   // Clearing on the last tail cycle guarantees the next frame starts from state 0.
   conv_enc_core #(.K(K), .G0(G0), .G1(G1)) u_core (
      .clk      (clk),
      .rst      (rst),
      .clr      (abort_i || tail_last),
      .shift_en (shift_en),
      .bit_i    (enc_bit),
      .sym_o    (sym)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         tail_cnt    <= '0;
         frame_cnt_o <= '0;
      end else if (abort_i) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         tail_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  bit_cnt <= BC_W'(1);
                  state   <= (FRAME_LEN == 1) ? ST_TAIL : ST_DATA;
               end
            end
            ST_DATA: begin
               if (accept) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) state <= ST_TAIL;
               end
            end
            ST_TAIL: begin
               if (tail_last) begin
                  state       <= ST_IDLE;
                  bit_cnt     <= '0;
                  tail_cnt    <= '0;
                  frame_cnt_o <= frame_cnt_o + 1'b1;
               end else begin
                  tail_cnt <= tail_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_o <= 1'b0;
         sof_o   <= 1'b0;
         eof_o   <= 1'b0;
         d_out   <= 2'b00;
      end else begin
         valid_o <= shift_en;
         sof_o   <= accept && (state == ST_IDLE);
         eof_o   <= tail_last;
         if (shift_en) d_out <= sym;
      end
   end

endmodule

// File: tb/tb_conv_tx_framer.sv
// Directed bench for conv_tx_framer: short-frame instance plus default and tiny-counter instances.
module tb_conv_tx_framer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Main instance: FRAME_LEN=4, K=3
   logic        in_valid = 1'b0, d_in = 1'b0, abort = 1'b0;
   logic        in_ready_o, valid_o, sof_o, eof_o, busy_o;
   logic [1:0]  d_out;
   logic [15:0] frame_cnt_o;

   conv_tx_framer #(.FRAME_LEN(4)) dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_o), .d_in(d_in),
      .abort_i(abort), .valid_o(valid_o), .d_out(d_out), .sof_o(sof_o), .eof_o(eof_o),
      .busy_o(busy_o), .frame_cnt_o(frame_cnt_o));

   // Default-parameter instance
   logic        valid_d = 1'b0, din_d = 1'b0, abort_d = 1'b0;
   logic        rdy_d, vo_d, sof_d, eof_d, busy_d;
   logic [1:0]  dout_d;
   logic [15:0] fc_d;

   conv_tx_framer dut_d (
      .clk(clk), .rst(rst), .in_valid_i(valid_d), .in_ready_o(rdy_d), .d_in(din_d),
      .abort_i(abort_d), .valid_o(vo_d), .d_out(dout_d), .sof_o(sof_d), .eof_o(eof_d),
      .busy_o(busy_d), .frame_cnt_o(fc_d));

   // Wrap instance: FRAME_LEN=1, CNT_W=2
   logic        valid_w = 1'b0, din_w = 1'b0, abort_w = 1'b0;
   logic        rdy_w, vo_w, sof_w, eof_w, busy_w;
   logic [1:0]  dout_w;
   logic [1:0]  fc_w;

   conv_tx_framer #(.FRAME_LEN(1), .CNT_W(2)) dut_w (
      .clk(clk), .rst(rst), .in_valid_i(valid_w), .in_ready_o(rdy_w), .d_in(din_w),
      .abort_i(abort_w), .valid_o(vo_w), .d_out(dout_w), .sof_o(sof_w), .eof_o(eof_w),
      .busy_o(busy_w), .frame_cnt_o(fc_w));

   // Output capture
   int         cyc = 0;
   logic [1:0] got_q[$];
   bit         sof_q[$];
   bit         eof_q[$];
   int         cyc_q[$];
   int         nd = 0, nz = 0, eofpos_d = 0, sofpos_d = 0;
   logic [1:0] got_w[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (valid_o) begin
         got_q.push_back(d_out);
         sof_q.push_back(sof_o);
         eof_q.push_back(eof_o);
         cyc_q.push_back(cyc);
      end
      if (vo_d) begin
         nd++;
         if (dout_d != 2'b00) nz++;
         if (eof_d) eofpos_d = nd;
         if (sof_d) sofpos_d = nd;
      end
      if (vo_w) got_w.push_back(dout_w);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ones(input bit q[$]);
      int s = 0;
      foreach (q[i]) s += int'(q[i]);
      return s;
   endfunction

   task automatic clear_q();
      got_q.delete(); sof_q.delete(); eof_q.delete(); cyc_q.delete();
   endtask

   task automatic send(input logic [7:0] bits, input int n, input int gap_at, input int gap_len);
      for (int i = 0; i < n; i++) begin
         int wt = 0;
         in_valid = 1'b1;
         d_in     = bits[n-1-i];
         while (!in_ready_o && wt < 20) begin
            @(posedge clk); #1;
            wt++;
         end
         if (wt >= 20) chk("ready_timeout", 32'd0, 32'd1);
         @(posedge clk); #1;
         if (i + 1 == gap_at) begin
            in_valid = 1'b0;
            repeat (gap_len) @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic chk_seq(input string tag, input logic [1:0] e[]);
      chk({tag, "_len"}, got_q.size(), e.size());
      for (int i = 0; i < e.size() && i < got_q.size(); i++)
         chk($sformatf("%s_pair%0d", tag, i), got_q[i], e[i]);
   endtask

   logic [1:0] seq_1011[] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
   logic [1:0] seq_b2b[]  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11,
                              2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
   logic [1:0] seq_1000[] = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};

   initial begin
      int lowc;
      #12 rst = 1'b1;
      #1;
      chk("rst_valid", valid_o, 0);
      chk("rst_dout", d_out, 0);
      chk("rst_sof", sof_o, 0);
      chk("rst_eof", eof_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ready", in_ready_o, 1);
      chk("rst_fcnt", frame_cnt_o, 0);
      @(negedge clk);

      // Frame 1011, continuous valid
      clear_q();
      send(8'b1011, 4, 0, 0);
      chk("s1_busy_tail", busy_o, 1);
      lowc = 0;
      while (!in_ready_o && lowc < 10) begin
         @(posedge clk); #1;
         lowc++;
      end
      chk("s1_ready_low_cycles", lowc, 2);
      drain();
      chk_seq("s1", seq_1011);
      chk("s1_sof_first", sof_q[0], 1);
      chk("s1_sof_count", ones(sof_q), 1);
      chk("s1_eof_last", eof_q[5], 1);
      chk("s1_eof_count", ones(eof_q), 1);
      chk("s1_fcnt", frame_cnt_o, 1);
      chk("s1_idle", busy_o, 0);

      // Same frame with a 3-cycle valid gap after bit 2
      clear_q();
      send(8'b1011, 4, 2, 3);
      drain();
      chk_seq("s2", seq_1011);
      chk("s2_gap", cyc_q[2] - cyc_q[1], 4);
      chk("s2_nogap", cyc_q[1] - cyc_q[0], 1);
      chk("s2_fcnt", frame_cnt_o, 2);

      // Back-to-back frames 1011, 1000
      clear_q();
      send(8'b1011, 4, 0, 0);
      send(8'b1000, 4, 0, 0);
      drain();
      chk_seq("s3", seq_b2b);
      chk("s3_sof2", sof_q[6], 1);
      chk("s3_eof1", eof_q[5], 1);
      chk("s3_eof2", eof_q[11], 1);
      chk("s3_bubble", cyc_q[6] - cyc_q[5], 1);
      chk("s3_fcnt", frame_cnt_o, 4);

      // Abort after the 2nd accepted bit, with a bit offered in the abort cycle
      clear_q();
      send(8'b10, 2, 0, 0);
      abort = 1'b1; in_valid = 1'b1; d_in = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; in_valid = 1'b0;
      chk("s4_busy", busy_o, 0);
      chk("s4_valid", valid_o, 0);
      chk("s4_eof", eof_o, 0);
      drain();
      chk("s4_pairs", got_q.size(), 2);
      chk("s4_fcnt", frame_cnt_o, 4);
      clear_q();
      send(8'b1011, 4, 0, 0);
      drain();
      chk_seq("s4b", seq_1011);
      chk("s4b_fcnt", frame_cnt_o, 5);

      // Async reset during the tail
      send(8'b1011, 4, 0, 0);
      @(posedge clk); #1;
      chk("s5_pre_valid", valid_o, 1);
      rst = 1'b0;
      #1;
      chk("s5_valid", valid_o, 0);
      chk("s5_dout", d_out, 0);
      chk("s5_busy", busy_o, 0);
      chk("s5_fcnt", frame_cnt_o, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      clear_q();
      send(8'b1000, 4, 0, 0);
      drain();
      chk_seq("s5", seq_1000);
      chk("s5_fcnt_after", frame_cnt_o, 1);

      // Default parameters: 256 zero bits
      valid_d = 1'b1; din_d = 1'b0;
      repeat (256) @(posedge clk);
      #1;
      valid_d = 1'b0;
      chk("s6_ready_tail", rdy_d, 0);
      drain();
      chk("s6_pairs", nd, 258);
      chk("s6_nonzero", nz, 0);
      chk("s6_eofpos", eofpos_d, 258);
      chk("s6_sofpos", sofpos_d, 1);
      chk("s6_fcnt", fc_d, 1);

      // FRAME_LEN=1 frames on a 2-bit counter
      for (int f = 0; f < 4; f++) begin
         valid_w = 1'b1; din_w = 1'b1;
         @(posedge clk); #1;
         valid_w = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         if (f == 2) chk("s7_fcnt3", fc_w, 3);
      end
      chk("s7_wrap", fc_w, 0);
      chk("s7_pairs", got_w.size(), 12);
      chk("s7_p0", got_w[0], 2'b11);
      chk("s7_p1", got_w[1], 2'b10);
      chk("s7_p2", got_w[2], 2'b11);
      chk("s7_p3", got_w[3], 2'b11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_tx_framer.md
Name: conv_tx_framer

Overview:
Framed rate-1/2 convolutional encoder: the transmit-side counterpart of the Viterbi decoder.
- Accepts info bits through a valid/ready handshake and encodes each frame of FRAME_LEN bits.
- Appends K-1 zero tail bits so every frame ends in state 0; the decoder can then trace back from a known state.
- Output symbol pair plus valid drives the channel/decoder path directly, with start/end-of-frame markers for bench alignment and error counting.

Parameters:
K, 3, constraint length (2..9); encoder memory is K-1 bits
G0, 3'b111 (octal 7), generator for d_out[1], K bits, MSB taps the current input
G1, 3'b101 (octal 5), generator for d_out[0], K bits, MSB taps the current input
FRAME_LEN, 256, info bits per frame (>=1)
CNT_W, 16, width of frame counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
in_valid_i  in  1  d_in carries an info bit
in_ready_o  out  1  block accepts a bit this cycle
d_in  in  1  info bit
abort_i  in  1  synchronous frame abort
valid_o  out  1  d_out carries a coded symbol pair
d_out  out  2  coded symbols {G0 parity, G1 parity}
sof_o  out  1  first symbol pair of a frame (qualified by valid_o)
eof_o  out  1  last tail symbol pair of a frame (qualified by valid_o)
busy_o  out  1  state != IDLE
frame_cnt_o  out  CNT_W  completed frames, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst low, async): state IDLE, shift register sr[K-2:0]=0, bit counter 0, tail counter 0, valid_o/sof_o/eof_o=0, d_out=2'b00, frame_cnt_o=0.
- Encoding window w = {bit, sr[K-2:0]}. sr[K-2] is the most recent previous bit.
  - d_out[1] = ^(w & G0); d_out[0] = ^(w & G1).
  - After each encoded bit: sr <= {bit, sr[K-2:1]}.
- in_ready_o is combinational: 1 in IDLE and DATA, 0 in TAIL. A bit is accepted when in_valid_i && in_ready_o.
- States:
  - IDLE: on accept, encode the bit, assert sof on its output, bit counter=1, go to DATA. If FRAME_LEN==1, go to TAIL instead.
  - DATA: each accept encodes the bit and increments the bit counter. The accept that makes the count equal FRAME_LEN moves the block to TAIL. A cycle without an accept produces no output (valid_o=0 next cycle) and the state holds.
  - TAIL: every cycle, encode bit=0 unconditionally, K-1 cycles total. The last tail cycle asserts eof, increments frame_cnt_o, forces sr=0 and returns to IDLE.
- Latency: outputs are registered, so valid_o/d_out/sof_o/eof_o appear 1 cycle after the accept or tail cycle that produced them.
- Each frame emits exactly FRAME_LEN+K-1 valid symbol pairs.
- No output backpressure: the consumer must take every valid_o cycle.
- Back-to-back frames: in_ready_o rises the cycle after the last tail cycle, and the next frame starts from sr=0.
- abort_i has priority over everything:
  - Next edge: state IDLE, sr=0, counters cleared, valid_o/sof_o/eof_o=0.
  - frame_cnt_o is not incremented, and any bit offered that cycle is dropped.
  - Abort in IDLE is a no-op.
- d_out holds its last value while valid_o=0.
- Async reset mid-frame or mid-tail behaves exactly as reset: the partial frame is discarded with no eof.
- sof_o and eof_o are never asserted in the same cycle, since K>=2.

Decomposition:
- Package conv_tx_pkg: state enum (IDLE, DATA, TAIL); default K/G0/G1 constants; parity function; FRAME_LEN default shared with the decoder bench.
- Sub-module conv_enc_core, K/G0/G1 parameterised, holding sr and the parity logic. Interface: clk, rst, clr, shift_en, bit_i, sym_o[1:0].
- The top level owns the FSM, counters, handshake and output registers.

Test Plan:
- FRAME_LEN=4, K=3, bits 1,0,1,1 with continuous valid -> 6 valid pairs: 11,10,00,01,01,11. sof on the first pair, eof on the last, in_ready low for 2 cycles, frame_cnt_o=1.
- Same frame with in_valid_i low for 3 cycles after the 2nd bit -> identical symbol sequence, valid_o gaps of 3 cycles, no spurious output.
- Two back-to-back frames 1011 then 1000 -> second frame begins with 11 (state cleared), frame_cnt_o=2, 12 valid pairs total.
- abort_i after the 2nd accepted bit -> next cycle busy_o=0 with no eof; frame_cnt_o unchanged. The following frame 1011 reproduces the full first-scenario sequence.
- rst pulsed low during the tail -> all outputs 0 immediately; frame_cnt_o=0; the next frame encodes from the zero state.
- Default params, 256 all-zero bits -> 258 pairs all 00, eof on pair 258. Also force frame_cnt_o to 2^CNT_W-1 and complete one frame -> wraps to 0.
